// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX byte scheduler.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SHIFT,
    STUFF,
    EOP
  } tx_state_t;

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned STUFF_RUN = 6;

endpackage

// File: rtl/usb_tx_byte_sched_if.sv
// Upstream TX-buffer byte stream: valid/ready handshake with last-byte qualifier.
interface usb_tx_byte_sched_if;
  import usb_tx_pkg::*;

  logic                 byte_valid;
  logic [BYTE_BITS-1:0] byte_data;
  logic                 byte_last;
  logic                 byte_ready;

  modport master (output byte_valid, output byte_data, output byte_last, input byte_ready);
  modport slave  (input byte_valid, input byte_data, input byte_last, output byte_ready);

endinterface

// File: rtl/tx_bit_timer.sv
// Bit-time pacing counter: wraps every CLKS_PER_BIT clocks, strobes on the last clock.
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic strobe_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign strobe_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || strobe_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/usb_tx_byte_sched.sv
// Sequencer for the USB TX parallel-to-serial shifter: byte fetch, bit pacing, EOP.
// Optional bit stuffing is enabled by defining USB_TX_BITSTUFF_EN.
module usb_tx_byte_sched
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned EOP_BITS     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  usb_tx_byte_sched_if.slave   up,
  output logic [BYTE_BITS-1:0] sr_data,
  output logic                 sr_load,
  output logic                 sr_shift,
  input  logic                 serial_in,
  output logic                 stuff_bit,
  output logic                 bit_strobe,
  output logic                 tx_active,
  output logic                 eop,
  output logic                 tx_done,
  output logic                 tx_error
);

  localparam int unsigned BIT_W = $clog2(BYTE_BITS);
  localparam int unsigned EOP_W = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;
  localparam int unsigned CNT_W = (EOP_W > BIT_W) ? EOP_W : BIT_W;

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timer_clr;
  logic             strobe;
  logic             do_bit;

`ifdef USB_TX_BITSTUFF_EN
  logic [2:0] ones_q, ones_d;
`else
  logic unused_serial;
  assign unused_serial = serial_in;
  assign stuff_bit     = 1'b0;
`endif

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (timer_clr),
    .strobe_o (strobe)
  );

  assign sr_data       = up.byte_data;
  assign up.byte_ready = sr_load;
  assign tx_active     = (state_q == SHIFT) || (state_q == STUFF) || (state_q == EOP);
  assign eop           = (state_q == EOP);
  assign tx_done       = done_q;
  assign tx_error      = err_q;

  // Next-state and strobe decode; do_bit marks the end-of-bit action (shift, reload, EOP or abort).
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    timer_clr  = 1'b0;
    do_bit     = 1'b0;
    bit_strobe = strobe;
`ifdef USB_TX_BITSTUFF_EN
    ones_d     = ones_q;
    stuff_bit  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (tx_start) begin
          state_d = WAIT;
`ifdef USB_TX_BITSTUFF_EN
          ones_d  = '0;
`endif
        end
      end
      WAIT: begin
        timer_clr = 1'b1;
        if (up.byte_valid) begin
          sr_load   = 1'b1;
          bit_cnt_d = '0;
          last_d    = up.byte_last;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (strobe) begin
`ifdef USB_TX_BITSTUFF_EN
          // Sixth consecutive one: defer this bit's action by one stuffed bit time
          if (serial_in && (ones_q == 3'(STUFF_RUN - 1))) begin
            ones_d  = '0;
            state_d = STUFF;
          end else begin
            ones_d = serial_in ? (ones_q + 3'd1) : 3'd0;
            do_bit = 1'b1;
          end
`else
          do_bit = 1'b1;
`endif
        end
      end
`ifdef USB_TX_BITSTUFF_EN
      STUFF: begin
        stuff_bit = 1'b1;
        if (strobe) begin
          state_d = SHIFT;
          do_bit  = 1'b1;
        end
      end
`endif
      EOP: begin
        if (strobe) begin
          if (bit_cnt_q == CNT_W'(EOP_BITS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_bit) begin
      if (bit_cnt_q != CNT_W'(BYTE_BITS - 1)) begin
        sr_shift  = 1'b1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end else if (last_q) begin
        state_d   = EOP;
        bit_cnt_d = '0;
`ifdef USB_TX_BITSTUFF_EN
        ones_d    = '0;
`endif
      end else if (up.byte_valid) begin
        sr_load   = 1'b1;
        bit_cnt_d = '0;
        last_d    = up.byte_last;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end

    // Reset overrides every request, including combinational strobes
    if (rst) begin
      state_d    = IDLE;
      sr_load    = 1'b0;
      sr_shift   = 1'b0;
      bit_strobe = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
`ifdef USB_TX_BITSTUFF_EN
      stuff_bit  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
      ones_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef USB_TX_BITSTUFF_EN
      ones_q    <= ones_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_tx_byte_sched.sv
// Scoreboard bench for usb_tx_byte_sched with upstream buffer and shifter models.
module tb_usb_tx_byte_sched;
  import usb_tx_pkg::*;

  localparam int CPB      = 8;
  localparam int EOPB     = 2;
  localparam int EOP_CLKS = CPB * EOPB;

  typedef enum int {EV_LOAD, EV_SHIFT, EV_BIT, EV_STUFF, EV_EOP, EV_DONE, EV_ERR} ev_e;
  typedef struct {
    ev_e        kind;
    int         t;
    logic [7:0] d;
  } ev_t;
  typedef struct {
    logic [7:0] d;
    logic       last;
  } up_t;

  logic       clk, rst, tx_start, serial_in;
  logic [7:0] sr_data;
  logic       sr_load, sr_shift, stuff_bit, bit_strobe, tx_active, eop, tx_done, tx_error;

  usb_tx_byte_sched_if up_if();

  usb_tx_byte_sched #(.CLKS_PER_BIT(CPB), .EOP_BITS(EOPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_start   (tx_start),
    .up         (up_if),
    .sr_data    (sr_data),
    .sr_load    (sr_load),
    .sr_shift   (sr_shift),
    .serial_in  (serial_in),
    .stuff_bit  (stuff_bit),
    .bit_strobe (bit_strobe),
    .tx_active  (tx_active),
    .eop        (eop),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   base = 0;
  bit   base_set = 0;
  bit   score_en = 1;
  ev_t  exp_q[$];
  up_t  up_q[$];
  int   eop_cycles, done_cnt, err_cnt, stuff_cycles, active_cycles, strobe_cnt;
  int   load_cnt, shift_cnt, eop_rel;
  bit   overlap, ready_bad, eop_prev, stuff_prev;
  logic [7:0] shreg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream buffer and shifter models, updated just after each rising edge
  initial begin : drv
    bit took, ld, sh;
    logic [7:0] d;
    up_if.byte_valid = 1'b0;
    up_if.byte_data  = 8'h00;
    up_if.byte_last  = 1'b0;
    shreg            = 8'h00;
    serial_in        = 1'b0;
    forever begin
      @(negedge clk);
      took = up_if.byte_valid && up_if.byte_ready;
      ld   = sr_load;
      sh   = sr_shift;
      d    = sr_data;
      @(posedge clk);
      #1;
      if (took && up_q.size() > 0) void'(up_q.pop_front());
      if (ld)      shreg = d;
      else if (sh) shreg = shreg >> 1;
      serial_in        = shreg[0];
      up_if.byte_valid = (up_q.size() > 0);
      up_if.byte_data  = (up_q.size() > 0) ? up_q[0].d : 8'h00;
      up_if.byte_last  = (up_q.size() > 0) ? up_q[0].last : 1'b0;
    end
  end

  // Monitor: collects statistics and scores observed events against the expected queue
  always @(negedge clk) begin : mon
    ev_t obs[$];
    ev_t e;
    cyc++;
    if (sr_load && !base_set) begin
      base_set = 1'b1;
      base     = cyc;
    end
    if (eop)        eop_cycles++;
    if (tx_done)    done_cnt++;
    if (tx_error)   err_cnt++;
    if (stuff_bit)  stuff_cycles++;
    if (tx_active)  active_cycles++;
    if (bit_strobe) strobe_cnt++;
    if (sr_load)    load_cnt++;
    if (sr_shift)   shift_cnt++;
    if (sr_load && sr_shift) overlap = 1'b1;
    if (up_if.byte_ready !== sr_load) ready_bad = 1'b1;
    if (eop && !eop_prev && base_set) eop_rel = cyc - base;
    if (score_en && base_set) begin
      obs.delete();
      if (bit_strobe && tx_active && !eop && !stuff_bit) obs.push_back('{EV_BIT, cyc - base, 8'(serial_in)});
      if (sr_shift)               obs.push_back('{EV_SHIFT, cyc - base, 8'h00});
      if (sr_load)                obs.push_back('{EV_LOAD, cyc - base, sr_data});
      if (stuff_bit && !stuff_prev) obs.push_back('{EV_STUFF, cyc - base, 8'h00});
      if (eop && !eop_prev)       obs.push_back('{EV_EOP, cyc - base, 8'h00});
      if (tx_done)                obs.push_back('{EV_DONE, cyc - base, 8'h00});
      if (tx_error)               obs.push_back('{EV_ERR, cyc - base, 8'h00});
      foreach (obs[i]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got kind=%0d t=%0d d=%h, none expected", obs[i].kind, obs[i].t, obs[i].d);
        end else begin
          e = exp_q.pop_front();
          if (obs[i].kind !== e.kind || obs[i].t !== e.t || obs[i].d !== e.d) begin
            errors++;
            $display("FAIL sb_event got kind=%0d t=%0d d=%h expected kind=%0d t=%0d d=%h",
                     obs[i].kind, obs[i].t, obs[i].d, e.kind, e.t, e.d);
          end
        end
      end
    end
    eop_prev   = eop;
    stuff_prev = stuff_bit;
  end

  // Reference timeline relative to the first load of a packet
  task automatic build_exp(input logic [7:0] b[$], input bit underrun);
    int t;
    bit last;
    logic [7:0] cur;
`ifdef USB_TX_BITSTUFF_EN
    int ones;
    ones = 0;
`endif
    t = 0;
    exp_q.push_back('{EV_LOAD, 0, b[0]});
    for (int i = 0; i < b.size(); i++) begin
      cur  = b[i];
      last = (i == b.size() - 1) && !underrun;
      for (int k = 0; k < 8; k++) begin
        t += CPB;
        exp_q.push_back('{EV_BIT, t, 8'(cur[k])});
`ifdef USB_TX_BITSTUFF_EN
        if (cur[k] && ones == 5) begin
          ones = 0;
          exp_q.push_back('{EV_STUFF, t + 1, 8'h00});
          t += CPB;
        end else begin
          ones = cur[k] ? ones + 1 : 0;
        end
`endif
        if (k < 7) exp_q.push_back('{EV_SHIFT, t, 8'h00});
        else if (last) begin
          exp_q.push_back('{EV_EOP, t + 1, 8'h00});
          exp_q.push_back('{EV_DONE, t + 1 + EOP_CLKS, 8'h00});
        end else if (i < b.size() - 1) exp_q.push_back('{EV_LOAD, t, b[i+1]});
        else exp_q.push_back('{EV_ERR, t + 1, 8'h00});
      end
    end
  endtask

  task automatic clear_stats();
    base_set = 1'b0;
    exp_q.delete();
    eop_cycles = 0; done_cnt = 0; err_cnt = 0; stuff_cycles = 0; active_cycles = 0;
    strobe_cnt = 0; load_cnt = 0; shift_cnt = 0; eop_rel = -1;
    overlap = 1'b0; ready_bad = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b[$], input bit underrun);
    clear_stats();
    build_exp(b, underrun);
    foreach (b[i]) up_q.push_back('{b[i], (i == b.size() - 1) && !underrun});
    @(posedge clk); #1;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_end(input int max, input int p1, input int p2, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      tx_start = (i == p1) || (i == p2);
      if (done_cnt + err_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    tx_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    score_en = 1'b0;
    clear_stats();
    rst = 1'b1; tx_start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sr_load, sr_shift, up_if.byte_ready, stuff_bit, bit_strobe, tx_active, eop, tx_done, tx_error} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 000000000",
               {sr_load, sr_shift, up_if.byte_ready, stuff_bit, bit_strobe, tx_active, eop, tx_done, tx_error});
    end
    @(posedge clk); #1;
    rst = 1'b0; tx_start = 1'b0;
    up_q.push_back('{8'h11, 1'b1});
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (load_cnt !== 0) begin
      errors++;
      $display("FAIL reset_beats_start got loads=%0d expected 0", load_cnt);
    end
    up_q.delete();
    repeat (3) @(posedge clk);
    #1;
    score_en = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [7:0] b[$];
    bit ok;
    b.push_back(8'hA5);
    send_packet(b, 1'b0);
    wait_end(400, -1, -1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got %0d expected 1", ok); end
    checks++; if (load_cnt !== 1) begin errors++; $display("FAIL single_loads got %0d expected 1", load_cnt); end
    checks++; if (shift_cnt !== 7) begin errors++; $display("FAIL single_shifts got %0d expected 7", shift_cnt); end
    checks++; if (eop_cycles !== EOP_CLKS) begin errors++; $display("FAIL single_eop_len got %0d expected %0d", eop_cycles, EOP_CLKS); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done got %0d expected 1", done_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL single_error got %0d expected 0", err_cnt); end
    checks++; if (active_cycles !== 8 * CPB + EOP_CLKS) begin errors++; $display("FAIL single_active got %0d expected %0d", active_cycles, 8 * CPB + EOP_CLKS); end
    checks++; if (strobe_cnt !== 8 + EOPB) begin errors++; $display("FAIL single_strobes got %0d expected %0d", strobe_cnt, 8 + EOPB); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL single_load_shift_overlap got %0d expected 0", overlap); end
    checks++; if (ready_bad !== 1'b0) begin errors++; $display("FAIL single_ready_vs_load got %0d expected 0", ready_bad); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_drain got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    bit ok;
    b.push_back(8'h01);
    b.push_back(8'h80);
    send_packet(b, 1'b0);
    wait_end(600, -1, -1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout got %0d expected 1", ok); end
    checks++; if (load_cnt !== 2) begin errors++; $display("FAIL b2b_loads got %0d expected 2", load_cnt); end
    checks++; if (shift_cnt !== 14) begin errors++; $display("FAIL b2b_shifts got %0d expected 14", shift_cnt); end
    checks++; if (eop_rel !== 16 * CPB + 1) begin errors++; $display("FAIL b2b_eop_start got %0d expected %0d", eop_rel, 16 * CPB + 1); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL b2b_load_shift_overlap got %0d expected 0", overlap); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_drain got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_underrun();
    logic [7:0] b[$];
    bit ok;
    b.push_back(8'h55);
    send_packet(b, 1'b1);
    wait_end(400, -1, -1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL underrun_timeout got %0d expected 1", ok); end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL underrun_error got %0d expected 1", err_cnt); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL underrun_done got %0d expected 0", done_cnt); end
    checks++; if (eop_cycles !== 0) begin errors++; $display("FAIL underrun_eop got %0d expected 0", eop_cycles); end
    checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL underrun_active got %0d expected 0", tx_active); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL underrun_drain got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_bitstuff();
    logic [7:0] b[$];
    bit ok;
`ifdef USB_TX_BITSTUFF_EN
    localparam int EXP_STUFF = CPB;
    localparam int EXP_EOP   = 9 * CPB + 1;
`else
    localparam int EXP_STUFF = 0;
    localparam int EXP_EOP   = 8 * CPB + 1;
`endif
    b.push_back(8'hFF);
    send_packet(b, 1'b0);
    wait_end(400, -1, -1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stuff_timeout got %0d expected 1", ok); end
    checks++; if (stuff_cycles !== EXP_STUFF) begin errors++; $display("FAIL stuff_cycles got %0d expected %0d", stuff_cycles, EXP_STUFF); end
    checks++; if (eop_rel !== EXP_EOP) begin errors++; $display("FAIL stuff_eop_start got %0d expected %0d", eop_rel, EXP_EOP); end
    checks++; if (shift_cnt !== 7) begin errors++; $display("FAIL stuff_shifts got %0d expected 7", shift_cnt); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL stuff_load_shift_overlap got %0d expected 0", overlap); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stuff_drain got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] b[$];
    bit ok;
    int n;
    score_en = 1'b0;
    clear_stats();
    up_q.push_back('{8'hF0, 1'b1});
    @(posedge clk); #1; tx_start = 1'b1;
    @(posedge clk); #1; tx_start = 1'b0;
    n = 0;
    while (!base_set && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (base_set !== 1'b1) begin errors++; $display("FAIL midrst_load_timeout got %0d expected 1", base_set); end
    repeat (26) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sr_load, sr_shift, up_if.byte_ready, stuff_bit, bit_strobe, tx_active, eop, tx_done, tx_error} !== 9'b0) begin
      errors++;
      $display("FAIL midrst_outputs got %b expected 000000000",
               {sr_load, sr_shift, up_if.byte_ready, stuff_bit, bit_strobe, tx_active, eop, tx_done, tx_error});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    up_q.delete();
    repeat (40) @(posedge clk);
    #1;
    checks++; if (eop_cycles !== 0) begin errors++; $display("FAIL midrst_eop got %0d expected 0", eop_cycles); end
    checks++; if (done_cnt + err_cnt !== 0) begin errors++; $display("FAIL midrst_done_err got %0d expected 0", done_cnt + err_cnt); end
    score_en = 1'b1;
    b.push_back(8'h3C);
    send_packet(b, 1'b0);
    wait_end(400, -1, -1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midrst_retx_timeout got %0d expected 1", ok); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL midrst_retx_done got %0d expected 1", done_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL midrst_retx_drain got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] b[$];
    bit ok;
    b.push_back(8'h01);
    b.push_back(8'h80);
    send_packet(b, 1'b0);
    wait_end(600, 20, 90, ok);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ignstart_timeout got %0d expected 1", ok); end
    checks++; if (load_cnt !== 2) begin errors++; $display("FAIL ignstart_loads got %0d expected 2", load_cnt); end
    checks++; if (eop_rel !== 16 * CPB + 1) begin errors++; $display("FAIL ignstart_eop_start got %0d expected %0d", eop_rel, 16 * CPB + 1); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ignstart_done got %0d expected 1", done_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ignstart_drain got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_bitstuff();
    test_reset_mid_packet();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
